// File: rtl/seg_scan_display_if.sv
// Bus between a debug-word source and the 4-digit multiplexed 7-segment scanner.
// master drives the word/strobes; slave (the scanner) drives the display lines.
interface seg_scan_display_if;
  logic [31:0] data_in;
  logic        load;
  logic        page;
  logic [3:0]  sel_seg;
  logic [7:0]  out_data;
  logic        frame_done;

  modport master (
    output data_in, load, page,
    input  sel_seg, out_data, frame_done
  );

  modport slave (
    input  data_in, load, page,
    output sel_seg, out_data, frame_done
  );
endinterface

// File: rtl/seg_scan_display.sv
// 4-digit hex scanner with per-slot blanking and frame-aligned shadow data.
// Optional macro SEG_LZ_SUPPRESS_EN blanks leading-zero digits 3..1.
module seg_scan_display #(
  parameter int DIV   = 50000,
  parameter int BLANK = 1000
) (
  input logic               clk,
  input logic               rst,
  seg_scan_display_if.slave bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK);

  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  logic [31:0]   pending;
  logic [31:0]   shadow;
  logic          page_q;
  logic [3:0]    sel_seg_q;
  logic [7:0]    out_data_q;
  logic          frame_done_q;

  logic          slot_end;
  logic          frame_end;
  logic          blank;
  logic [15:0]   half;
  logic [3:0]    nibble;
  logic          lz_blank;
  logic [7:0]    lit_data;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Segment pattern for the current slot, built from the frame-stable shadow copy.
  always_comb begin
    slot_end  = (cnt == CNT_MAX);
    frame_end = slot_end && (digit == 2'd3);
    blank     = (cnt < BLANK_END);
    half      = page_q ? shadow[31:16] : shadow[15:0];
    nibble    = half[{digit, 2'b00} +: 4];
`ifdef SEG_LZ_SUPPRESS_EN
    lz_blank  = (digit != 2'd0) && ((half >> {digit, 2'b00}) == 16'h0000);
`else
    lz_blank  = 1'b0;
`endif
    lit_data  = {~(page_q && (digit == 2'd0)), hex7(nibble)};
    if (lz_blank) begin
      lit_data = 8'hFF;
    end
  end

  // A load on the boundary cycle bypasses pending so the new value is not a frame late.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      digit        <= 2'd0;
      pending      <= 32'h0;
      shadow       <= 32'h0;
      page_q       <= 1'b0;
      sel_seg_q    <= 4'hF;
      out_data_q   <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt          <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) begin
        digit <= digit + 2'd1;
      end
      if (bus.load) begin
        pending <= bus.data_in;
      end
      if (frame_end) begin
        shadow <= bus.load ? bus.data_in : pending;
        page_q <= bus.page;
      end
      frame_done_q <= frame_end;
      sel_seg_q    <= blank ? 4'hF  : ~(4'b0001 << digit);
      out_data_q   <= blank ? 8'hFF : lit_data;
    end
  end

  assign bus.sel_seg    = sel_seg_q;
  assign bus.out_data   = out_data_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream consumer of the CPU top's debug word, i.e. the 32-bit value read back at addr_sel. Drives the 4-digit multiplexed 7-segment display.
- Time-multiplexes 4 hex digits of a selected halfword onto active-low digit enables and segment lines.
- Blanks the display between digit slots to suppress ghosting.
- Holds a shadow copy of the data that updates only at frame boundaries, so a changing CPU value never produces a torn frame.

Parameters:
- DIV, 50000: clock cycles per digit slot; legal range DIV >= 4.
- BLANK, 1000: cycles at the start of each slot with all digits off; legal range 1 <= BLANK < DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, active-high, synchronous to clk.
- data_in  input  32  word to display.
- load  input  1  one-cycle strobe; captures data_in as the pending value.
- page  input  1  0 = show data_in[15:0], 1 = show data_in[31:16].
- sel_seg  output  4  digit enables, active-low; bit 0 = rightmost digit.
- out_data  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset: rst is sampled on the clk rising edge. Cleared state and outputs:
  - cnt=0, digit=0, pending=0, shadow=0, page_q=0.
  - sel_seg=4'hF, out_data=8'hFF, frame_done=0.
  - Asserting rst mid-frame aborts the frame immediately; the next frame starts from digit 0 with shadow=0.
- Slot counter:
  - cnt counts 0..DIV-1 and wraps.
  - At cnt==DIV-1, digit increments, wrapping 3 -> 0.
  - One frame = 4*DIV cycles.
- Frame boundary (cnt==DIV-1 and digit==3):
  - shadow <= pending and page_q <= page.
  - frame_done pulses high in the following cycle.
- Load:
  - load=1 sets pending <= data_in.
  - If load coincides with the frame boundary, data_in goes straight to shadow (load wins), and pending also takes data_in.
  - A load mid-frame does not affect the current frame.
- Outputs: registered, one cycle behind cnt/digit.
  - When cnt < BLANK: sel_seg=4'hF, out_data=8'hFF.
  - Otherwise: sel_seg has only bit[digit] low, and out_data = hex encode of nibble[digit] of the selected halfword (halfword chosen by page_q).
- Hex encoding, active-low, 0..F:
  - 0..7: C0, F9, A4, B0, 99, 92, 82, F8.
  - 8..F: 80, 90, 88, 83, C6, A1, 86, 8E.
- Decimal point: dp (bit 7) is driven low on digit 0 when page_q=1, indicating the upper halfword; otherwise dp is high.
- Slot timing: the first lit slot after reset deassertion begins BLANK+1 cycles later.
- All counters wrap with no saturation; no other state exists.

Optional Feature:
- Macro: SEG_LZ_SUPPRESS_EN.
- Defined: digits 3..1 show out_data=8'hFF (sel_seg still driven normally) when that digit's nibble and every higher nibble of the displayed halfword are zero. Digit 0 is always shown.
- Undefined: all 4 digits are always shown, including leading zeros.

Test Plan (DIV=8, BLANK=2, frame = 32 cycles):
- Reset: hold rst 3 cycles mid-frame -> sel_seg=F, out_data=FF, frame_done=0 for every held cycle; the counter restarts at 0 on release.
- Load 0x1234ABCD with page=0 during frame 0:
  - Frame 0 shows C0 on all digits.
  - Frame 1 shows digits 0..3 = A1, C6, 83, 88 with sel_seg 1110, 1101, 1011, 0111.
  - frame_done pulses at cycles 32 and 64.
- Set page=1 with the same data -> the next frame shows 19 (4 with dp lit), B0, A4, F9; the change is applied only at the boundary.
- Blanking: first 2 cycles of every slot -> sel_seg=F, out_data=FF; cycles 3..8 of the slot are lit.
- Load 0x5 mid-frame -> the current frame is unchanged. Then load 0x7 exactly on the boundary cycle -> the next frame shows digit 0 = F8, not 92.
- SEG_LZ_SUPPRESS_EN defined, value 0x00000050, page=0 -> digits 3 and 2 show FF, digit 1 shows 92, digit 0 shows C0. Undefined -> digits 3 and 2 show C0.
